inv_mix_columns_iter: RTL

INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

---
 rtl/aes_pkg.sv | 26 ++
 rtl/inv_mix_single_column.sv | 16 +
 rtl/inv_mix_columns_iter.sv | 72 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) helpers and FSM state type shared by the InvMixColumns blocks.
package aes_pkg;
   localparam logic [7:0] AES_POLY = 8'h1b;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] mul09(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] mul0b(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] mul0d(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] mul0e(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction
endpackage

// File: rtl/inv_mix_single_column.sv
// inv_mix_single_column: combinational InvMixColumns of one column, a0 in bits [31:24].
module inv_mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);
   logic [7:0] a0, a1, a2, a3;

   assign {a0, a1, a2, a3} = col_in;

   assign col_out = {mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3),
                     mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3),
                     mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3),
                     mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3)};
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: handshaked AES InvMixColumns, one column per cycle by default.
// Define INV_MIX_COLUMNS_UNROLL_EN to transform all four columns in a single cycle.
module inv_mix_columns_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   state_t       state, state_nxt;
   logic [127:0] w, w_nxt, w_xf;
   logic         busy_last;

   // byte (row r, column c) sits at bit 127-32r-8c of the packed state
`ifdef INV_MIX_COLUMNS_UNROLL_EN
   genvar c;
   for (c = 0; c < 4; c++) begin : g_col
      logic [31:0] ci, co;
      assign ci = {w[127-8*c -: 8], w[95-8*c -: 8], w[63-8*c -: 8], w[31-8*c -: 8]};
      inv_mix_single_column u_col (.col_in(ci), .col_out(co));
      assign {w_xf[127-8*c -: 8], w_xf[95-8*c -: 8], w_xf[63-8*c -: 8], w_xf[31-8*c -: 8]} = co;
   end
   assign busy_last = 1'b1;
`else
   logic [1:0]  col;
   logic [31:0] ci, co;

   inv_mix_single_column u_col (.col_in(ci), .col_out(co));

   always_comb begin
      ci = '0;
      for (int r = 0; r < 4; r++) ci[31-8*r -: 8] = w[127-32*r-8*int'(col) -: 8];
   end

   always_comb begin
      w_xf = w;
      for (int r = 0; r < 4; r++) w_xf[127-32*r-8*int'(col) -: 8] = co[31-8*r -: 8];
   end

   assign busy_last = (col == 2'd3);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) col <= '0;
      else        col <= (state == BUSY) ? col + 2'd1 : 2'd0;
`endif

   always_comb begin
      state_nxt = (state == IDLE && in_valid)  ? BUSY :
                  (state == BUSY && busy_last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
      w_nxt     = (state == IDLE && in_valid)  ? in_data :
                  (state == BUSY)              ? w_xf : w;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         w     <= '0;
      end else begin
         state <= state_nxt;
         w     <= w_nxt;
      end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_data  = w;
endmodule
